// File: rtl/btn_pkg.sv
// Shared types, default parameters and sizing helper for the paddle button front-end.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_t;

    localparam int DEF_N_BTN         = 4;
    localparam int DEF_TICK_DIV      = 65000;
    localparam int DEF_STABLE_MS     = 10;
    localparam int DEF_REPEAT_DLY_MS = 300;
    localparam int DEF_REPEAT_MS     = 50;

    // Counter width for a count of n distinct values, never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_fsm.sv
// One button: 2-FF synchroniser, debounce and press/hold/auto-repeat sequencer
// driven by the shared millisecond tick.
//
//  state     | meaning
//  IDLE      | released, waiting for the synced input to go high
//  PRESS_CHK | input high, counting ms of stability before accepting the press
//  HELD      | press accepted, counting ms toward the next auto-repeat step
//  REL_CHK   | input low while held, counting ms before accepting the release
module btn_fsm
    import btn_pkg::*;
#(
    parameter int STABLE_MS     = DEF_STABLE_MS,
    parameter int REPEAT_DLY_MS = DEF_REPEAT_DLY_MS,
    parameter int REPEAT_MS     = DEF_REPEAT_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic step
);

    localparam int CNT_W = width_of(REPEAT_DLY_MS + 1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_MS);
    localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(REPEAT_DLY_MS);
    localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DLY_MS - REPEAT_MS);

    logic             sync_a;
    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt == DLY_C) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
            step   <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            btn_s  <= sync_a;
            press  <= 1'b0;
            rel    <= 1'b0;
            step   <= 1'b0;
            // An input change always takes priority over a coincident tick.
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt_inc == STABLE_C) begin
                            state <= HELD;
                            cnt   <= '0;
                            level <= 1'b1;
                            press <= 1'b1;
                            step  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt_inc == DLY_C) begin
                            step <= 1'b1;
                            cnt  <= RELOAD_C;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                REL_CHK: begin
                    // A bounce back into HELD resumes the short repeat period.
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= RELOAD_C;
                    end else if (tick) begin
                        if (cnt_inc == STABLE_C) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                            rel   <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_scheduler.sv
// Paddle button front-end: ms prescaler, per-button debounce/repeat FSMs,
// per-paddle up/down arbitration with last-pressed-wins, and output enable gating.
module button_scheduler
    import btn_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int STABLE_MS     = DEF_STABLE_MS,
    parameter int REPEAT_DLY_MS = DEF_REPEAT_DLY_MS,
    parameter int REPEAT_MS     = DEF_REPEAT_MS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [N_BTN-1:0]   btn_step,
    output logic [N_BTN/2-1:0] move_up,
    output logic [N_BTN/2-1:0] move_dn
);

    localparam int N_PAD = N_BTN / 2;
    localparam int PRE_W = width_of(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [N_BTN-1:0] press_raw;
    logic [N_BTN-1:0] rel_raw;
    logic [N_BTN-1:0] step_raw;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_fsm #(
            .STABLE_MS     (STABLE_MS),
            .REPEAT_DLY_MS (REPEAT_DLY_MS),
            .REPEAT_MS     (REPEAT_MS)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .btn_raw (btn_raw[i]),
            .level   (btn_level[i]),
            .press   (press_raw[i]),
            .rel     (rel_raw[i]),
            .step    (step_raw[i])
        );
    end

    // Pulses are gated, not held back, so nothing is replayed when en returns.
    assign btn_press   = press_raw & {N_BTN{en}};
    assign btn_release = rel_raw   & {N_BTN{en}};
    assign btn_step    = step_raw  & {N_BTN{en}};

    for (genvar k = 0; k < N_PAD; k++) begin : g_pad
        logic pu, pd, lu, ld;
        logic eff_tie, eff_dn;
        logic last_dn, tie, up_q, dn_q;

        assign pu = press_raw[2*k];
        assign pd = press_raw[2*k+1];
        assign lu = btn_level[2*k];
        assign ld = btn_level[2*k+1];

        // Fold this cycle's presses in so the registered move never lags a new press.
        assign eff_tie = (pu & pd) | (~pu & ~pd & tie);
        assign eff_dn  = (pu ^ pd) ? pd : last_dn;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_dn <= 1'b0;
                tie     <= 1'b0;
                up_q    <= 1'b0;
                dn_q    <= 1'b0;
            end else begin
                last_dn <= eff_dn;
                tie     <= eff_tie;
                up_q    <= lu & (~ld | (~eff_tie & ~eff_dn));
                dn_q    <= ld & (~lu | (~eff_tie &  eff_dn));
            end
        end

        assign move_up[k] = up_q & en;
        assign move_dn[k] = dn_q & en;
    end

endmodule

// File: tb/tb_button_scheduler.sv
// Self-checking bench for button_scheduler: directed scenarios plus random
// button activity, all compared each cycle against a behavioural model.
module tb_button_scheduler;

    localparam int NB = 4;
    localparam int NP = 2;
    localparam int TD = 4;
    localparam int SM = 3;
    localparam int RD = 6;
    localparam int RM = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_step;
    logic [NP-1:0] move_up, move_dn;

    int checks = 0;
    int passes = 0;

    button_scheduler #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_MS(SM), .REPEAT_DLY_MS(RD), .REPEAT_MS(RM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_step(btn_step), .move_up(move_up), .move_dn(move_dn)
    );

    always #5 clk = ~clk;

    // Behavioural model: debounced level flips after SM ticks of a steady
    // disagreeing input; repeats counted in ms; arbitration by press timestamps.
    logic [NB-1:0] m_s1, m_s2, m_prev, m_level, m_press, m_rel, m_step;
    logic [NP-1:0] m_up, m_dn;
    int            m_cyc;
    int            m_dev [NB];
    int            m_rep [NB];
    int            m_tup [NP];
    int            m_tdn [NP];
    bit            m_tk;
    logic [NB-1:0] m_s, m_lvl_old;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_step = '0; m_up = '0; m_dn = '0;
            m_cyc = 0;
            for (int b = 0; b < NB; b++) begin m_dev[b] = 0; m_rep[b] = 0; end
            for (int p = 0; p < NP; p++) begin m_tup[p] = -1; m_tdn[p] = -1; end
        end else begin
            m_tk      = ((m_cyc % TD) == TD - 1);
            m_s       = m_s2;
            m_lvl_old = m_level;
            for (int p = 0; p < NP; p++) begin
                m_up[p] = m_lvl_old[2*p]   && (!m_lvl_old[2*p+1] || m_tup[p] > m_tdn[p]);
                m_dn[p] = m_lvl_old[2*p+1] && (!m_lvl_old[2*p]   || m_tdn[p] > m_tup[p]);
            end
            m_press = '0; m_rel = '0; m_step = '0;
            for (int b = 0; b < NB; b++) begin
                if (m_s[b] != m_prev[b]) begin
                    m_dev[b] = 0;
                    if (m_level[b] && m_s[b]) m_rep[b] = RD - RM;
                end else if (m_tk) begin
                    if (m_s[b] != m_level[b]) begin
                        m_dev[b]++;
                        if (m_dev[b] == SM) begin
                            m_dev[b]   = 0;
                            m_level[b] = m_s[b];
                            if (m_s[b]) begin
                                m_press[b] = 1'b1;
                                m_step[b]  = 1'b1;
                                m_rep[b]   = 0;
                            end else begin
                                m_rel[b] = 1'b1;
                            end
                        end
                    end else if (m_level[b]) begin
                        m_rep[b]++;
                        if (m_rep[b] == RD) begin
                            m_step[b] = 1'b1;
                            m_rep[b]  = RD - RM;
                        end
                    end
                end
            end
            m_prev = m_s;
            for (int p = 0; p < NP; p++) begin
                if (m_press[2*p])   m_tup[p] = m_cyc;
                if (m_press[2*p+1]) m_tdn[p] = m_cyc;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_cyc++;
        end
    end

    logic [4*NB+2*NP-1:0] dut_vec, exp_vec;
    assign dut_vec = {btn_level, btn_press, btn_release, btn_step, move_up, move_dn};
    assign exp_vec = {m_level, m_press & {NB{en}}, m_rel & {NB{en}}, m_step & {NB{en}},
                      m_up & {NP{en}}, m_dn & {NP{en}}};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; btn_raw = '0;
        repeat (3) cyc();
        checks++;
        if (dut_vec !== '0) $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        else passes++;
        rst_n = 1'b1;
        repeat (10) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_clean_press();
        int npress, first;
        logic mv_at, mv_after;
        npress = 0; first = -1; mv_at = 1'bx; mv_after = 1'bx;
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL clean_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (btn_press[0]) begin npress++; if (first < 0) begin first = i; mv_at = move_up[0]; end end
            if (first > 0 && i == first + 1) mv_after = move_up[0];
        end
        checks++;
        if (npress != 1) $display("FAIL clean_press_count got=%0d exp=1", npress); else passes++;
        checks++;
        if (first < 12 || first > 16) $display("FAIL clean_press_latency got=%0d exp=12..16", first); else passes++;
        checks++;
        if (mv_at !== 1'b0 || mv_after !== 1'b1)
            $display("FAIL clean_move_delay got=%b%b exp=01", mv_at, mv_after);
        else passes++;
        checks++;
        if (btn_level[0] !== 1'b1 || move_up[0] !== 1'b1 || move_dn[0] !== 1'b0)
            $display("FAIL clean_held got=%b%b%b exp=110", btn_level[0], move_up[0], move_dn[0]);
        else passes++;
        btn_raw[0] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL clean_rel_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_bounce();
        int npress, first, pat_len;
        int pat [3];
        logic lv [3];
        pat[0] = 8; pat[1] = 1; pat[2] = 20;
        lv[0] = 1'b1; lv[1] = 1'b0; lv[2] = 1'b1;
        npress = 0; first = -1; pat_len = 0;
        for (int seg = 0; seg < 3; seg++) begin
            btn_raw[0] = lv[seg];
            for (int i = 1; i <= pat[seg]; i++) begin
                cyc();
                pat_len++;
                checks++;
                if (dut_vec !== exp_vec) $display("FAIL bounce_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
                else passes++;
                if (btn_press[0]) begin npress++; if (first < 0) first = pat_len - 9; end
            end
        end
        checks++;
        if (npress != 1) $display("FAIL bounce_press_count got=%0d exp=1", npress); else passes++;
        checks++;
        if (first < 12 || first > 16) $display("FAIL bounce_latency got=%0d exp=12..16", first); else passes++;
        btn_raw[0] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL bounce_rel_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_repeat();
        int steps[$];
        int rel_at;
        rel_at = -1;
        btn_raw[1] = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL repeat_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (btn_step[1]) steps.push_back(i);
        end
        btn_raw[1] = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL repeat_rel_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (btn_step[1]) steps.push_back(60 + i);
            if (btn_release[1] && rel_at < 0) rel_at = i;
        end
        checks++;
        if (steps.size() < 4) $display("FAIL repeat_step_count got=%0d exp>=4", steps.size());
        else passes++;
        for (int j = 1; j < steps.size(); j++) begin
            checks++;
            if (steps[j] - steps[j-1] != ((j == 1) ? RD * TD : RM * TD))
                $display("FAIL repeat_gap_%0d got=%0d exp=%0d", j, steps[j] - steps[j-1], (j == 1) ? RD * TD : RM * TD);
            else passes++;
        end
        checks++;
        if (rel_at < 12 || rel_at > 16) $display("FAIL repeat_release_latency got=%0d exp=12..16", rel_at);
        else passes++;
    endtask

    task automatic test_last_wins();
        btn_raw[0] = 1'b1;
        repeat (20) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL lastwin_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        btn_raw[1] = 1'b1;
        repeat (20) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL lastwin_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (move_up[0] !== 1'b0 || move_dn[0] !== 1'b1)
            $display("FAIL lastwin_dn got=%b%b exp=01", move_up[0], move_dn[0]);
        else passes++;
        btn_raw[1] = 1'b0;
        repeat (20) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL lastwin_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (move_up[0] !== 1'b1 || move_dn[0] !== 1'b0)
            $display("FAIL lastwin_up_back got=%b%b exp=10", move_up[0], move_dn[0]);
        else passes++;
        btn_raw[0] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL lastwin_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_tie();
        int bad;
        bad = 0;
        btn_raw[1:0] = 2'b11;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL tie_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (move_up[0] || move_dn[0]) bad++;
        end
        checks++;
        if (bad != 0 || btn_level[1:0] !== 2'b11)
            $display("FAIL tie_both_zero got_moves=%0d lvl=%b exp_moves=0 lvl=11", bad, btn_level[1:0]);
        else passes++;
        btn_raw[1] = 1'b0;
        repeat (20) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL tie_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (move_up[0] !== 1'b1 || move_dn[0] !== 1'b0)
            $display("FAIL tie_resolve got=%b%b exp=10", move_up[0], move_dn[0]);
        else passes++;
        btn_raw[0] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL tie_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int nrel, first;
        btn_raw[2] = 1'b1;
        repeat (8) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) $display("FAIL rst_presschk got=%h exp=0", dut_vec); else passes++;
        cyc();
        rst_n = 1'b1;
        repeat (30) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) $display("FAIL rst_held got=%h exp=0", dut_vec); else passes++;
        cyc();
        rst_n = 1'b1;
        nrel = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (btn_release != '0) nrel++;
            if (btn_press[2] && first < 0) first = i;
        end
        checks++;
        if (nrel != 0) $display("FAIL rst_no_release got=%0d exp=0", nrel); else passes++;
        checks++;
        if (first < 12 || first > 16) $display("FAIL rst_recount got=%0d exp=12..16", first); else passes++;
        btn_raw[2] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_enable();
        int npulse;
        npulse = 0;
        en = 1'b0;
        btn_raw[3] = 1'b1;
        repeat (40) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL en_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if ((btn_press | btn_step | btn_release) != '0 || (move_up | move_dn) != '0) npulse++;
        end
        checks++;
        if (npulse != 0) $display("FAIL en_gated got=%0d exp=0", npulse); else passes++;
        checks++;
        if (btn_level[3] !== 1'b1) $display("FAIL en_level got=%b exp=1", btn_level[3]); else passes++;
        en = 1'b1;
        npulse = 0;
        repeat (3) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL en_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
            if (btn_press[3]) npulse++;
        end
        checks++;
        if (npulse != 0) $display("FAIL en_no_queue got=%0d exp=0", npulse); else passes++;
        btn_raw[3] = 1'b0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL en_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_random();
        int hold [NB];
        for (int b = 0; b < NB; b++) hold[b] = $urandom_range(1, 30);
        repeat (4000) begin
            for (int b = 0; b < NB; b++) begin
                if (hold[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 20);
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL random_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
        en = 1'b1;
        btn_raw = '0;
        repeat (25) begin
            cyc();
            checks++;
            if (dut_vec !== exp_vec) $display("FAIL random_settle t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_last_wins();
        test_tie();
        test_reset_mid();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
